// File: rtl/sms_arb_pkg.sv
// -----------------------------------------------------------------------------
// sms_arb_pkg
// Shared definitions for the two-master sms bank arbiter:
//   - AHB-lite HTRANS / HRESP encodings
//   - master index type
//   - input-stage FSM state enum
//   - hold-register control struct (address is held separately because its
//     width is a parameter of the arbiter)
//   - held_trans(): issue-time htrans for a held transfer
// -----------------------------------------------------------------------------
package sms_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Wide enough for the full STARVE_MAX range (1..255).
    localparam int BEAT_CNT_W = 8;

    typedef logic mst_idx_t;
    localparam mst_idx_t MST_0 = 1'b0;
    localparam mst_idx_t MST_1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // no request held, no data phase owned
        ST_WAIT = 2'b01,  // lost arbitration, address phase held, master stalled
        ST_DATA = 2'b10   // owns the bank data phase
    } stage_st_e;

    typedef struct packed {
        logic [1:0] htrans;
        logic       hwrite;
        logic [2:0] hsize;
        logic [3:0] hprot;
    } hold_ctrl_t;

    // A held transfer always reaches the bank after another master's beat,
    // so it can never continue a bank-side burst: a held SEQ goes out as NONSEQ.
    function automatic logic [1:0] held_trans(input logic [1:0] trans);
        return (trans == HTRANS_SEQ) ? HTRANS_NONSEQ : trans;
    endfunction

endpackage : sms_arb_pkg

// File: rtl/sms_bank_arb2_in_stage.sv
// -----------------------------------------------------------------------------
// sms_arb_in_stage
// Per-master input stage: hold register plus IDLE/WAIT/DATA FSM.
//   IDLE : idle response (ready=1, OKAY, rdata=0)
//   WAIT : holds the losing address phase, stalls the master (ready=0)
//   DATA : owns the bank data phase, bank ready/resp/rdata passed through
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   live_i                master presents a valid address phase this cycle
//   gnt_i                 arbiter grants this master's request this cycle
//   s_hready_resp_i       bank ready (ends the data phase)
//   haddr_i, ctrl_i       live address/control from the master
//   s_hrdata_i, s_hresp_i bank read data / response
//   pending_o             a held request is waiting (state WAIT)
//   held_addr_o/ctrl_o    hold register contents
//   hready_resp_o, hresp_o, hrdata_o   response to the master
// -----------------------------------------------------------------------------
module sms_arb_in_stage
    import sms_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              live_i,
    input  logic              gnt_i,
    input  logic              s_hready_resp_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  hold_ctrl_t        ctrl_i,
    input  logic [31:0]       s_hrdata_i,
    input  logic [1:0]        s_hresp_i,
    output logic              pending_o,
    output logic [ADDR_W-1:0] held_addr_o,
    output hold_ctrl_t        held_ctrl_o,
    output logic              hready_resp_o,
    output logic [1:0]        hresp_o,
    output logic [31:0]       hrdata_o
);

    stage_st_e         state_q, state_d;
    logic              capture;
    logic [ADDR_W-1:0] held_addr_q;
    hold_ctrl_t        held_ctrl_q;

    // A new address phase can be accepted when idle, or in the last cycle of
    // our own data phase (pipelined back-to-back request).
    logic slot_open;
    assign slot_open = (state_q == ST_IDLE) ||
                       ((state_q == ST_DATA) && s_hready_resp_i);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        capture = 1'b0;
        if (state_q == ST_WAIT) begin
            if (gnt_i) state_d = ST_DATA;
        end else if (slot_open) begin
            if (gnt_i) begin
                state_d = ST_DATA;
            end else if (live_i) begin
                state_d = ST_WAIT;
                capture = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the hold payload is not reset; it is only read while state_q is
    // WAIT, and WAIT is always entered through a capture.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            held_addr_q <= haddr_i;
            held_ctrl_q <= ctrl_i;
        end
    end

    always_comb begin
        hready_resp_o = 1'b1;
        hresp_o       = HRESP_OKAY;
        hrdata_o      = '0;
        unique case (state_q)
            ST_WAIT: hready_resp_o = 1'b0;
            ST_DATA: begin
                hready_resp_o = s_hready_resp_i;
                hresp_o       = s_hresp_i;
                hrdata_o      = s_hrdata_i;
            end
            default: ;
        endcase
    end

    assign pending_o   = (state_q == ST_WAIT);
    assign held_addr_o = held_addr_q;
    assign held_ctrl_o = held_ctrl_q;

endmodule : sms_arb_in_stage

// File: rtl/sms_bank_arb2.sv
// -----------------------------------------------------------------------------
// sms_bank_arb2
// Two-master AHB-lite arbiter in front of one sms SRAM bank slave port.
// m0 = CPU data bus, m1 = DMA. A live winner passes to the bank with no added
// wait; a loser is held in its input stage and stalled. The bank data-phase
// response is routed to the owning master only.
// Parameters:
//   ADDR_W      address width on all ports
//   STARVE_MAX  consecutive beats one master may keep in a SEQ run while the
//               other master is requesting (1..255)
// Configuration macro:
//   SMS_ARB_FIXED_PRIO_EN  defined: ties go to m0; otherwise round-robin.
// Ports:
//   mem_hclk, mem_hrst       clock, synchronous active-high reset
//   mX_h*  (X=0,1)           master AHB-lite address/data inputs and response
//   s_h*                     bank-side AHB-lite address/data and response
//   arb_idle                 nothing pending and no data phase outstanding
// -----------------------------------------------------------------------------
module sms_bank_arb2
    import sms_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              mem_hclk,
    input  logic              mem_hrst,
    // master 0 (CPU)
    input  logic              m0_hsel,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [3:0]        m0_hprot,
    input  logic [31:0]       m0_hwdata,
    input  logic              m0_hready,
    output logic [31:0]       m0_hrdata,
    output logic              m0_hready_resp,
    output logic [1:0]        m0_hresp,
    // master 1 (DMA)
    input  logic              m1_hsel,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [3:0]        m1_hprot,
    input  logic [31:0]       m1_hwdata,
    input  logic              m1_hready,
    output logic [31:0]       m1_hrdata,
    output logic              m1_hready_resp,
    output logic [1:0]        m1_hresp,
    // bank
    output logic              s_hsel,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [3:0]        s_hprot,
    output logic [31:0]       s_hwdata,
    output logic              s_hready,
    input  logic [31:0]       s_hrdata,
    input  logic              s_hready_resp,
    input  logic [1:0]        s_hresp,
    // status
    output logic              arb_idle
);

    // ---------------------------------------------------------------- requests
    logic       live0, live1;
    hold_ctrl_t ctrl0, ctrl1;

    // BUSY/IDLE have htrans[1]=0 and are never treated as requests.
    assign live0 = m0_hsel & m0_htrans[1] & m0_hready;
    assign live1 = m1_hsel & m1_htrans[1] & m1_hready;
    assign ctrl0 = '{htrans: m0_htrans, hwrite: m0_hwrite, hsize: m0_hsize, hprot: m0_hprot};
    assign ctrl1 = '{htrans: m1_htrans, hwrite: m1_hwrite, hsize: m1_hsize, hprot: m1_hprot};

    // ---------------------------------------------------------------- state
    logic                  dp_valid_q,   dp_valid_d;
    mst_idx_t              dp_owner_q,   dp_owner_d;
    mst_idx_t              last_grant_q, last_grant_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q,   beat_cnt_d;

    // ---------------------------------------------------------------- stages
    logic              pend0, pend1;
    logic [ADDR_W-1:0] held_addr0, held_addr1;
    hold_ctrl_t        held_ctrl0, held_ctrl1;
    logic              gnt_any;
    mst_idx_t          win;
    logic              gnt0, gnt1;

    assign gnt0 = gnt_any && (win == MST_0);
    assign gnt1 = gnt_any && (win == MST_1);

    sms_arb_in_stage #(.ADDR_W(ADDR_W)) u_stage0 (
        .clk_i           (mem_hclk),
        .rst_i           (mem_hrst),
        .live_i          (live0),
        .gnt_i           (gnt0),
        .s_hready_resp_i (s_hready_resp),
        .haddr_i         (m0_haddr),
        .ctrl_i          (ctrl0),
        .s_hrdata_i      (s_hrdata),
        .s_hresp_i       (s_hresp),
        .pending_o       (pend0),
        .held_addr_o     (held_addr0),
        .held_ctrl_o     (held_ctrl0),
        .hready_resp_o   (m0_hready_resp),
        .hresp_o         (m0_hresp),
        .hrdata_o        (m0_hrdata)
    );

    sms_arb_in_stage #(.ADDR_W(ADDR_W)) u_stage1 (
        .clk_i           (mem_hclk),
        .rst_i           (mem_hrst),
        .live_i          (live1),
        .gnt_i           (gnt1),
        .s_hready_resp_i (s_hready_resp),
        .haddr_i         (m1_haddr),
        .ctrl_i          (ctrl1),
        .s_hrdata_i      (s_hrdata),
        .s_hresp_i       (s_hresp),
        .pending_o       (pend1),
        .held_addr_o     (held_addr1),
        .held_ctrl_o     (held_ctrl1),
        .hready_resp_o   (m1_hready_resp),
        .hresp_o         (m1_hresp),
        .hrdata_o        (m1_hrdata)
    );

    // ---------------------------------------------------------------- arbiter
    logic grant_pt;
    logic req0, req1;
    logic owner_seq;
    logic starved;

    // A stage in WAIT already has its request in the hold register; its
    // master is stalled, so the live path is ignored for it.
    assign req0 = pend0 | (live0 & ~pend0);
    assign req1 = pend1 | (live1 & ~pend1);

    assign grant_pt = s_hready_resp | ~dp_valid_q;

    // The last granted master is the burst owner; it keeps the bank while it
    // continues with live SEQ beats, until the starvation limit is reached.
    assign owner_seq = (last_grant_q == MST_0)
                     ? (live0 & ~pend0 & (m0_htrans == HTRANS_SEQ))
                     : (live1 & ~pend1 & (m1_htrans == HTRANS_SEQ));
    assign starved   = (beat_cnt_q >= BEAT_CNT_W'(STARVE_MAX));

    always_comb begin
        gnt_any = 1'b0;
        win     = MST_0;
        if (!mem_hrst && grant_pt) begin
            if (req0 && req1) begin
                gnt_any = 1'b1;
                if (owner_seq && !starved) begin
                    win = last_grant_q;
                end else if (owner_seq) begin
                    win = ~last_grant_q;
                end else begin
`ifdef SMS_ARB_FIXED_PRIO_EN
                    win = MST_0;
`else
                    win = ~last_grant_q;
`endif
                end
            end else if (req0) begin
                gnt_any = 1'b1;
                win     = MST_0;
            end else if (req1) begin
                gnt_any = 1'b1;
                win     = MST_1;
            end
        end
    end

    // ---------------------------------------------------------------- bank address phase
    always_comb begin
        s_hsel   = 1'b0;
        s_haddr  = '0;
        s_htrans = HTRANS_IDLE;
        s_hwrite = 1'b0;
        s_hsize  = '0;
        s_hprot  = '0;
        if (gnt_any) begin
            s_hsel = 1'b1;
            if (win == MST_0) begin
                if (pend0) begin
                    s_haddr  = held_addr0;
                    s_htrans = held_trans(held_ctrl0.htrans);
                    s_hwrite = held_ctrl0.hwrite;
                    s_hsize  = held_ctrl0.hsize;
                    s_hprot  = held_ctrl0.hprot;
                end else begin
                    s_haddr  = m0_haddr;
                    s_htrans = m0_htrans;
                    s_hwrite = m0_hwrite;
                    s_hsize  = m0_hsize;
                    s_hprot  = m0_hprot;
                end
            end else begin
                if (pend1) begin
                    s_haddr  = held_addr1;
                    s_htrans = held_trans(held_ctrl1.htrans);
                    s_hwrite = held_ctrl1.hwrite;
                    s_hsize  = held_ctrl1.hsize;
                    s_hprot  = held_ctrl1.hprot;
                end else begin
                    s_haddr  = m1_haddr;
                    s_htrans = m1_htrans;
                    s_hwrite = m1_hwrite;
                    s_hsize  = m1_hsize;
                    s_hprot  = m1_hprot;
                end
            end
        end
    end

    // Write data belongs to the data phase, so it follows the data-phase owner;
    // a held master is in its own data phase and still drives hwdata.
    assign s_hwdata = (dp_owner_q == MST_1) ? m1_hwdata : m0_hwdata;
    assign s_hready = s_hready_resp;
    assign arb_idle = ~dp_valid_q & ~pend0 & ~pend1;

    // ---------------------------------------------------------------- next state
    always_comb begin
        dp_valid_d   = dp_valid_q;
        dp_owner_d   = dp_owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        if (grant_pt) begin
            dp_valid_d = gnt_any;
            if (gnt_any) dp_owner_d = win;
        end
        if (gnt_any) begin
            last_grant_d = win;
            // The granted beat itself opens a new run on NONSEQ or owner change.
            if ((win != last_grant_q) || (s_htrans == HTRANS_NONSEQ)) begin
                beat_cnt_d = BEAT_CNT_W'(1);
            end else if (beat_cnt_q != '1) begin
                beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge mem_hclk) begin
        if (mem_hrst) begin
            dp_valid_q   <= 1'b0;
            dp_owner_q   <= MST_0;
            last_grant_q <= MST_1;
            beat_cnt_q   <= '0;
        end else begin
            dp_valid_q   <= dp_valid_d;
            dp_owner_q   <= dp_owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule : sms_bank_arb2

// File: tb/tb_sms_bank_arb2.sv
// -----------------------------------------------------------------------------
// tb_sms_bank_arb2
// Directed bench for sms_bank_arb2 (STARVE_MAX = 2). The bench plays both
// masters and the bank; each master's hready is tied to its hready_resp as on
// a single-slave AHB-lite bus. Inputs change 1 time unit after the rising
// edge, outputs are checked 1 unit later.
// -----------------------------------------------------------------------------
module tb_sms_bank_arb2;
    import sms_arb_pkg::*;

`ifdef SMS_ARB_FIXED_PRIO_EN
    localparam int TIE_FIRST = 0;   // ties always to m0
`else
    localparam int TIE_FIRST = 1;   // last_grant = m0 before each tie -> m1
`endif

    logic        mem_hclk = 1'b0;
    logic        mem_hrst;
    logic        m0_hsel, m1_hsel;
    logic [31:0] m0_haddr, m1_haddr;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [3:0]  m0_hprot, m1_hprot;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic        m0_hready, m1_hready;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready_resp, m1_hready_resp;
    logic [1:0]  m0_hresp, m1_hresp;
    logic        s_hsel;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [3:0]  s_hprot;
    logic [31:0] s_hwdata;
    logic        s_hready;
    logic [31:0] s_hrdata;
    logic        s_hready_resp;
    logic [1:0]  s_hresp;
    logic        arb_idle;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 mem_hclk = ~mem_hclk;

    assign m0_hready = m0_hready_resp;
    assign m1_hready = m1_hready_resp;

    sms_bank_arb2 #(.ADDR_W(32), .STARVE_MAX(2)) dut (
        .mem_hclk(mem_hclk), .mem_hrst(mem_hrst),
        .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready),
        .m0_hrdata(m0_hrdata), .m0_hready_resp(m0_hready_resp), .m0_hresp(m0_hresp),
        .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready),
        .m1_hrdata(m1_hrdata), .m1_hready_resp(m1_hready_resp), .m1_hresp(m1_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hready(s_hready),
        .s_hrdata(s_hrdata), .s_hready_resp(s_hready_resp), .s_hresp(s_hresp),
        .arb_idle(arb_idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_hclk);
        #1;
    endtask

    task automatic drv(input int m, input logic [1:0] trans, input logic [31:0] addr, input logic wr);
        if (m == 0) begin
            m0_hsel = (trans != HTRANS_IDLE); m0_htrans = trans; m0_haddr = addr;
            m0_hwrite = wr; m0_hsize = 3'b010; m0_hprot = 4'b0011;
        end else begin
            m1_hsel = (trans != HTRANS_IDLE); m1_htrans = trans; m1_haddr = addr;
            m1_hwrite = wr; m1_hsize = 3'b010; m1_hprot = 4'b0011;
        end
    endtask

    task automatic idle_all();
        drv(0, HTRANS_IDLE, 32'h0, 1'b0);
        drv(1, HTRANS_IDLE, 32'h0, 1'b0);
    endtask

    task automatic bank(input logic rdy, input logic [1:0] resp, input logic [31:0] rdata);
        s_hready_resp = rdy; s_hresp = resp; s_hrdata = rdata;
    endtask

    function automatic logic get_rdy(input int m);
        return (m == 0) ? m0_hready_resp : m1_hready_resp;
    endfunction

    function automatic logic [31:0] get_rdata(input int m);
        return (m == 0) ? m0_hrdata : m1_hrdata;
    endfunction

    // Single m0 read, leaves last_grant = m0.
    task automatic single_m0(input logic [31:0] addr);
        idle_all(); bank(1'b1, HRESP_OKAY, 32'h0);
        drv(0, HTRANS_NONSEQ, addr, 1'b0);
        #1 check("single_addr", s_haddr, addr);
        tick();
        idle_all();
        #1;
        tick();
    endtask

    // m0 read a0 and m1 write a1 in the same cycle, with last_grant = m0.
    task automatic pair_test(input string tag, input logic [31:0] a0, input logic [31:0] a1);
        int          first, second;
        logic [31:0] fa, sa, rd;
        first  = TIE_FIRST;
        second = 1 - TIE_FIRST;
        fa = (first == 0) ? a0 : a1;
        sa = (first == 0) ? a1 : a0;
        rd = 32'hD0D0_0000 | sa;
        drv(0, HTRANS_NONSEQ, a0, 1'b0);
        drv(1, HTRANS_NONSEQ, a1, 1'b1);
        bank(1'b1, HRESP_OKAY, 32'h0);
        #1;
        check({tag, "_first_addr"}, s_haddr, fa);
        check({tag, "_first_wr"}, 32'(s_hwrite), 32'(first == 1));
        tick();
        idle_all();
        m0_hwdata = 32'h0000_AAAA; m1_hwdata = 32'h0000_BBBB;
        #1;
        check({tag, "_loser_stall"}, 32'(get_rdy(second)), 32'd0);
        check({tag, "_winner_rdy"}, 32'(get_rdy(first)), 32'd1);
        check({tag, "_held_addr"}, s_haddr, sa);
        check({tag, "_held_trans"}, 32'(s_htrans), 32'(HTRANS_NONSEQ));
        check({tag, "_hwdata_mux"}, s_hwdata, (first == 0) ? 32'h0000_AAAA : 32'h0000_BBBB);
        tick();
        bank(1'b1, HRESP_OKAY, rd);
        #1;
        check({tag, "_loser_rdy"}, 32'(get_rdy(second)), 32'd1);
        check({tag, "_loser_rdata"}, get_rdata(second), rd);
        tick();
    endtask

    initial begin
        mem_hrst = 1'b1;
        idle_all();
        m0_hwdata = '0; m1_hwdata = '0;
        bank(1'b1, HRESP_OKAY, 32'hDEAD_BEEF);
        tick(); tick();
        mem_hrst = 1'b0;
        #1;
        // ---- reset state
        check("rst_m0_rdy",   32'(m0_hready_resp), 32'd1);
        check("rst_m1_rdy",   32'(m1_hready_resp), 32'd1);
        check("rst_m0_resp",  32'(m0_hresp), 32'(HRESP_OKAY));
        check("rst_m0_rdata", m0_hrdata, 32'h0);
        check("rst_s_hsel",   32'(s_hsel), 32'd0);
        check("rst_s_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
        check("rst_arb_idle", 32'(arb_idle), 32'd1);
        tick();

        // ---- single m0 read, zero added latency
        drv(0, HTRANS_NONSEQ, 32'h100, 1'b0);
        #1;
        check("t1_s_haddr",  s_haddr, 32'h100);
        check("t1_s_htrans", 32'(s_htrans), 32'(HTRANS_NONSEQ));
        check("t1_m0_rdy_a", 32'(m0_hready_resp), 32'd1);
        tick();
        idle_all(); bank(1'b1, HRESP_OKAY, 32'hA5A5_0100);
        #1;
        check("t1_m0_rdy_d",  32'(m0_hready_resp), 32'd1);
        check("t1_m0_rdata",  m0_hrdata, 32'hA5A5_0100);
        check("t1_m1_rdata",  m1_hrdata, 32'h0);
        check("t1_busy",      32'(arb_idle), 32'd0);
        tick();
        #1 check("t1_idle", 32'(arb_idle), 32'd1);

        // ---- simultaneous NONSEQ (last_grant = m0)
        pair_test("t2", 32'h110, 32'h120);

        // ---- burst lock and starvation break (STARVE_MAX = 2)
        idle_all(); bank(1'b1, HRESP_OKAY, 32'h0);
        drv(0, HTRANS_NONSEQ, 32'h200, 1'b0);
        #1 check("t3_b0_addr", s_haddr, 32'h200);
        tick();
        drv(0, HTRANS_SEQ, 32'h204, 1'b0);
        drv(1, HTRANS_NONSEQ, 32'h280, 1'b0);
        #1;
        check("t3_b1_addr",  s_haddr, 32'h204);
        check("t3_b1_trans", 32'(s_htrans), 32'(HTRANS_SEQ));
        tick();
        drv(0, HTRANS_SEQ, 32'h208, 1'b0);
        drv(1, HTRANS_IDLE, 32'h0, 1'b0);
        #1;
        check("t3_switch_addr", s_haddr, 32'h280);
        check("t3_m1_stall",    32'(m1_hready_resp), 32'd0);
        check("t3_m0_rdy",      32'(m0_hready_resp), 32'd1);
        tick();
        drv(0, HTRANS_SEQ, 32'h20C, 1'b0);
        #1;
        check("t3_m0_stall",     32'(m0_hready_resp), 32'd0);
        check("t3_held_addr",    s_haddr, 32'h208);
        check("t3_held_nonseq",  32'(s_htrans), 32'(HTRANS_NONSEQ));
        tick();
        #1;
        check("t3_b3_addr",  s_haddr, 32'h20C);
        check("t3_b3_trans", 32'(s_htrans), 32'(HTRANS_SEQ));
        tick();
        idle_all();
        #1 check("t3_end_idle", 32'(s_htrans), 32'(HTRANS_IDLE));
        tick();

        // ---- bank ERROR on m1 write, m0 pending meanwhile
        drv(1, HTRANS_NONSEQ, 32'h300, 1'b1);
        #1;
        check("t4_addr", s_haddr, 32'h300);
        check("t4_wr",   32'(s_hwrite), 32'd1);
        tick();
        idle_all();
        m1_hwdata = 32'h0000_CAFE;
        drv(0, HTRANS_NONSEQ, 32'h310, 1'b0);
        bank(1'b0, HRESP_ERROR, 32'h0);
        #1;
        check("t4_e1_m1_rdy",  32'(m1_hready_resp), 32'd0);
        check("t4_e1_m1_resp", 32'(m1_hresp), 32'(HRESP_ERROR));
        check("t4_e1_m0_resp", 32'(m0_hresp), 32'(HRESP_OKAY));
        check("t4_e1_hwdata",  s_hwdata, 32'h0000_CAFE);
        check("t4_e1_noissue", 32'(s_htrans), 32'(HTRANS_IDLE));
        tick();
        idle_all();
        bank(1'b1, HRESP_ERROR, 32'h0);
        #1;
        check("t4_e2_m1_rdy",  32'(m1_hready_resp), 32'd1);
        check("t4_e2_m1_resp", 32'(m1_hresp), 32'(HRESP_ERROR));
        check("t4_e2_m0_stall", 32'(m0_hready_resp), 32'd0);
        check("t4_e2_m0_resp", 32'(m0_hresp), 32'(HRESP_OKAY));
        check("t4_e2_issue",   s_haddr, 32'h310);
        tick();
        bank(1'b1, HRESP_OKAY, 32'h0310_0310);
        #1;
        check("t4_m0_rdata", m0_hrdata, 32'h0310_0310);
        check("t4_m0_resp",  32'(m0_hresp), 32'(HRESP_OKAY));
        check("t4_m1_resp",  32'(m1_hresp), 32'(HRESP_OKAY));
        tick();
        #1 check("t4_idle", 32'(arb_idle), 32'd1);

        // ---- reset while m0 is held in WAIT
        drv(1, HTRANS_NONSEQ, 32'h500, 1'b0);
        #1 check("t5_m1_addr", s_haddr, 32'h500);
        tick();
        idle_all();
        drv(0, HTRANS_NONSEQ, 32'h510, 1'b0);
        bank(1'b0, HRESP_OKAY, 32'h0);
        #1 check("t5_no_gp", 32'(s_htrans), 32'(HTRANS_IDLE));
        tick();
        idle_all();
        mem_hrst = 1'b1;
        #1 check("t5_m0_wait", 32'(m0_hready_resp), 32'd0);
        tick();
        drv(0, HTRANS_NONSEQ, 32'h520, 1'b0);
        bank(1'b1, HRESP_OKAY, 32'h0);
        #1;
        check("t5_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
        check("t5_hsel",   32'(s_hsel), 32'd0);
        check("t5_m0_rdy", 32'(m0_hready_resp), 32'd1);
        check("t5_m1_rdy", 32'(m1_hready_resp), 32'd1);
        check("t5_idle",   32'(arb_idle), 32'd1);
        tick();
        mem_hrst = 1'b0;
        idle_all();
        #1;
        check("t5_post_idle",   32'(arb_idle), 32'd1);
        check("t5_post_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
        tick();

        // ---- four simultaneous pairs, each after an m0 single
        for (int i = 0; i < 4; i++) begin
            single_m0(32'h400 + 32'(i * 16));
            pair_test($sformatf("t6_%0d", i), 32'h404 + 32'(i * 16), 32'h408 + 32'(i * 16));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sms_bank_arb2
